// File: rtl/fmul_result_collector.sv
// Downstream collector for mul_top: follows issued ops through the fixed
// multiplier latency, buffers results in a FIFO and grants issue credit.
module fmul_result_collector #(
    parameter int EXPO_W = 8,
    parameter int MANT_W = 23,
    parameter int LAT    = 3,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue_valid,
    output logic                     issue_ready,
    input  logic [EXPO_W+MANT_W:0]   mul_res,
    input  logic [4:0]               mul_status,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXPO_W+MANT_W:0]   out_res,
    output logic [4:0]               out_status,
    output logic [4:0]               fflags,
    input  logic                     fflags_clr
);
    localparam int W  = EXPO_W + MANT_W + 1;
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = DEPTH[PW:0];

    logic [LAT-1:0] vsr;
    logic [LAT-1:0] vsr_next;
    logic [W+4:0]   mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [PW:0]    count;
    logic [PW:0]    occ;
    logic           accept;
    logic           capture;
    logic           pop;

    // Credit counts queued entries plus ops still inside the multiplier,
    // so every op that reaches capture already owns a FIFO slot.
    assign issue_ready = (occ < DEPTH_C);
    assign accept      = issue_valid && issue_ready;
    assign capture     = vsr[LAT-1];
    assign out_valid   = (count != '0);
    assign pop         = out_valid && out_ready;
    assign {out_res, out_status} = out_valid ? mem[rd_ptr] : '0;

    if (LAT == 1) begin : g_vsr_one
        assign vsr_next = accept;
    end else begin : g_vsr_shift
        assign vsr_next = {vsr[LAT-2:0], accept};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vsr    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            occ    <= '0;
            fflags <= '0;
        end else begin
            vsr <= vsr_next;
            if (capture) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;

            if (capture && !pop)      count <= count + 1'b1;
            else if (!capture && pop) count <= count - 1'b1;

            if (accept && !pop)       occ <= occ + 1'b1;
            else if (!accept && pop)  occ <= occ - 1'b1;

            if (fflags_clr)   fflags <= capture ? mul_status : '0;
            else if (capture) fflags <= fflags | mul_status;
        end
    end

    always_ff @(posedge clk) begin
        if (capture && !rst) mem[wr_ptr] <= {mul_res, mul_status};
    end
endmodule

// File: tb/tb_fmul_result_collector.sv
// Self-checking bench for fmul_result_collector against a queue-based model.
module tb_fmul_result_collector;
    localparam int EXPO_W = 8;
    localparam int MANT_W = 23;
    localparam int LAT    = 3;
    localparam int DEPTH  = 4;
    localparam int W      = EXPO_W + MANT_W + 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         issue_valid;
    logic         issue_ready;
    logic [W-1:0] mul_res;
    logic [4:0]   mul_status;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_res;
    logic [4:0]   out_status;
    logic [4:0]   fflags;
    logic         fflags_clr;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: result queue, due cycles of in-flight ops, sticky flags.
    logic [W+4:0] mq[$];
    int           pend[$];
    int           cyc = 0;
    logic [4:0]   mflags = '0;
    logic         e_valid;
    logic         e_ready;
    logic [W-1:0] e_res;
    logic [4:0]   e_status;

    fmul_result_collector #(
        .EXPO_W(EXPO_W),
        .MANT_W(MANT_W),
        .LAT(LAT),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .issue_valid(issue_valid),
        .issue_ready(issue_ready),
        .mul_res(mul_res),
        .mul_status(mul_status),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_res(out_res),
        .out_status(out_status),
        .fflags(fflags),
        .fflags_clr(fflags_clr)
    );

    always #5 clk = ~clk;

    task automatic model_expect();
        logic [W+4:0] h;
        h = '0;
        e_valid = (mq.size() != 0);
        if (e_valid) h = mq[0];
        e_res    = h[W+4:5];
        e_status = h[4:0];
        e_ready  = (mq.size() + pend.size()) < DEPTH;
    endtask

    task automatic model_advance();
        bit acc, cap, pop;
        if (rst) begin
            mq.delete();
            pend.delete();
            mflags = '0;
        end else begin
            acc = issue_valid && ((mq.size() + pend.size()) < DEPTH);
            cap = (pend.size() != 0) && (pend[0] == cyc);
            pop = (mq.size() != 0) && out_ready;
            if (pop) void'(mq.pop_front());
            if (cap) begin
                void'(pend.pop_front());
                mq.push_back({mul_res, mul_status});
            end
            if (acc) pend.push_back(cyc + LAT);
            if (fflags_clr)  mflags = cap ? mul_status : 5'b0;
            else if (cap)    mflags = mflags | mul_status;
        end
        cyc++;
    endtask

    task automatic tick();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_data();
        mul_res    = W'($urandom);
        mul_status = 5'($urandom);
    endtask

    task automatic settle();
        for (int k = 0; k < LAT + DEPTH + 2; k++) begin
            issue_valid = 1'b0; out_ready = 1'b1; fflags_clr = 1'b0; rand_data();
            @(negedge clk);
            model_expect();
            n_checks++;
            if (out_valid !== e_valid || out_res !== e_res || out_status !== e_status ||
                issue_ready !== e_ready || fflags !== mflags) begin
                n_fail++;
                $display("FAIL settle cyc=%0d got v=%b res=%h st=%b rdy=%b ff=%b want v=%b res=%h st=%b rdy=%b ff=%b",
                         cyc, out_valid, out_res, out_status, issue_ready, fflags, e_valid, e_res, e_status, e_ready, mflags);
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; issue_valid = 1'b0; out_ready = 1'b0; fflags_clr = 1'b0; rand_data();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tick();
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || out_res !== '0 || out_status !== 5'b0 ||
            fflags !== 5'b0 || issue_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state got v=%b res=%h st=%b ff=%b rdy=%b want v=0 res=0 st=0 ff=0 rdy=1",
                     out_valid, out_res, out_status, fflags, issue_ready);
        end
        tick();
    endtask

    task automatic test_single_op();
        for (int k = 0; k < 6; k++) begin
            issue_valid = (k == 0); out_ready = (k >= 4); fflags_clr = 1'b0; rand_data();
            if (k == 3) begin
                mul_res = 32'hCD26B307; mul_status = 5'b00001;
            end
            @(negedge clk);
            model_expect();
            n_checks++;
            if (out_valid !== e_valid || out_res !== e_res || out_status !== e_status ||
                issue_ready !== e_ready || fflags !== mflags) begin
                n_fail++;
                $display("FAIL single_model cyc=%0d got v=%b res=%h st=%b rdy=%b ff=%b want v=%b res=%h st=%b rdy=%b ff=%b",
                         cyc, out_valid, out_res, out_status, issue_ready, fflags, e_valid, e_res, e_status, e_ready, mflags);
            end
            if (k == 3) begin
                n_checks++;
                if (out_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL single_no_bypass got v=%b want v=0", out_valid);
                end
            end
            if (k == 4) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_res !== 32'hCD26B307 || out_status !== 5'b00001 || fflags !== 5'b00001) begin
                    n_fail++;
                    $display("FAIL single_result got v=%b res=%h st=%b ff=%b want v=1 res=cd26b307 st=00001 ff=00001",
                             out_valid, out_res, out_status, fflags);
                end
            end
            if (k == 5) begin
                n_checks++;
                if (out_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL single_popped got v=%b want v=0", out_valid);
                end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int acc = 0;
        int pops = 0;
        for (int k = 0; k < 10; k++) begin
            issue_valid = 1'b1; out_ready = 1'b0; fflags_clr = 1'b0; rand_data();
            @(negedge clk);
            model_expect();
            n_checks++;
            if (out_valid !== e_valid || out_res !== e_res || out_status !== e_status ||
                issue_ready !== e_ready || fflags !== mflags) begin
                n_fail++;
                $display("FAIL bp_model cyc=%0d got v=%b res=%h st=%b rdy=%b ff=%b want v=%b res=%h st=%b rdy=%b ff=%b",
                         cyc, out_valid, out_res, out_status, issue_ready, fflags, e_valid, e_res, e_status, e_ready, mflags);
            end
            if (issue_ready === 1'b1) acc++;
            if (k >= 4) begin
                n_checks++;
                if (issue_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_stall k=%0d got rdy=%b want rdy=0", k, issue_ready);
                end
            end
            tick();
        end
        n_checks++;
        if (acc != DEPTH) begin
            n_fail++;
            $display("FAIL bp_accepts got %0d want %0d", acc, DEPTH);
        end
        for (int k = 0; k < 6; k++) begin
            issue_valid = 1'b0; out_ready = 1'b1; fflags_clr = 1'b0; rand_data();
            @(negedge clk);
            model_expect();
            n_checks++;
            if (out_valid !== e_valid || out_res !== e_res || out_status !== e_status ||
                issue_ready !== e_ready || fflags !== mflags) begin
                n_fail++;
                $display("FAIL bp_drain cyc=%0d got v=%b res=%h st=%b rdy=%b ff=%b want v=%b res=%h st=%b rdy=%b ff=%b",
                         cyc, out_valid, out_res, out_status, issue_ready, fflags, e_valid, e_res, e_status, e_ready, mflags);
            end
            if (k < 2) begin
                n_checks++;
                if (issue_ready !== (k == 1)) begin
                    n_fail++;
                    $display("FAIL bp_credit_return k=%0d got rdy=%b want rdy=%b", k, issue_ready, (k == 1));
                end
            end
            if (out_valid === 1'b1) pops++;
            tick();
        end
        n_checks++;
        if (pops != DEPTH) begin
            n_fail++;
            $display("FAIL bp_pops got %0d want %0d", pops, DEPTH);
        end
    endtask

    task automatic test_streaming();
        int acc = 0;
        int pops = 0;
        for (int k = 0; k < 80 && pops < 20; k++) begin
            issue_valid = (acc < 20); out_ready = 1'b1; fflags_clr = 1'b0; rand_data();
            @(negedge clk);
            model_expect();
            n_checks++;
            if (out_valid !== e_valid || out_res !== e_res || out_status !== e_status ||
                issue_ready !== e_ready || fflags !== mflags) begin
                n_fail++;
                $display("FAIL stream_model cyc=%0d got v=%b res=%h st=%b rdy=%b ff=%b want v=%b res=%h st=%b rdy=%b ff=%b",
                         cyc, out_valid, out_res, out_status, issue_ready, fflags, e_valid, e_res, e_status, e_ready, mflags);
            end
            if (issue_valid && issue_ready === 1'b1) acc++;
            if (out_valid === 1'b1) pops++;
            tick();
        end
        n_checks++;
        if (pops != 20) begin
            n_fail++;
            $display("FAIL stream_count got %0d results want 20", pops);
        end
    endtask

    task automatic test_fflags();
        for (int k = 0; k < 8; k++) begin
            issue_valid = (k < 3); out_ready = 1'b1; fflags_clr = (k == 0) || (k == 5); rand_data();
            if (k == 3) mul_status = 5'b10000;
            if (k == 4) mul_status = 5'b00100;
            if (k == 5) mul_status = 5'b00010;
            @(negedge clk);
            model_expect();
            n_checks++;
            if (out_valid !== e_valid || out_res !== e_res || out_status !== e_status ||
                issue_ready !== e_ready || fflags !== mflags) begin
                n_fail++;
                $display("FAIL fflags_model cyc=%0d got v=%b res=%h st=%b rdy=%b ff=%b want v=%b res=%h st=%b rdy=%b ff=%b",
                         cyc, out_valid, out_res, out_status, issue_ready, fflags, e_valid, e_res, e_status, e_ready, mflags);
            end
            if (k == 5) begin
                n_checks++;
                if (fflags !== 5'b10100) begin
                    n_fail++;
                    $display("FAIL fflags_accum got %b want 10100", fflags);
                end
            end
            if (k == 6) begin
                n_checks++;
                if (fflags !== 5'b00010) begin
                    n_fail++;
                    $display("FAIL fflags_clr_capture got %b want 00010", fflags);
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_midflight();
        for (int k = 0; k < 10; k++) begin
            issue_valid = (k < 2); rst = (k == 2); out_ready = 1'b1; fflags_clr = 1'b0; rand_data();
            @(negedge clk);
            model_expect();
            n_checks++;
            if (out_valid !== e_valid || out_res !== e_res || out_status !== e_status ||
                issue_ready !== e_ready || fflags !== mflags) begin
                n_fail++;
                $display("FAIL rstmid_model cyc=%0d got v=%b res=%h st=%b rdy=%b ff=%b want v=%b res=%h st=%b rdy=%b ff=%b",
                         cyc, out_valid, out_res, out_status, issue_ready, fflags, e_valid, e_res, e_status, e_ready, mflags);
            end
            if (k >= 3) begin
                n_checks++;
                if (out_valid !== 1'b0 || fflags !== 5'b0 || issue_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rstmid_flush k=%0d got v=%b ff=%b rdy=%b want v=0 ff=0 rdy=1",
                             k, out_valid, fflags, issue_ready);
                end
            end
            tick();
        end
        rst = 1'b0;
    endtask

    task automatic test_empty_race();
        logic [W-1:0] saved;
        saved = '0;
        for (int k = 0; k < 6; k++) begin
            issue_valid = (k == 0); out_ready = 1'b1; fflags_clr = 1'b0; rand_data();
            if (k == 3) saved = mul_res;
            @(negedge clk);
            model_expect();
            n_checks++;
            if (out_valid !== e_valid || out_res !== e_res || out_status !== e_status ||
                issue_ready !== e_ready || fflags !== mflags) begin
                n_fail++;
                $display("FAIL race_model cyc=%0d got v=%b res=%h st=%b rdy=%b ff=%b want v=%b res=%h st=%b rdy=%b ff=%b",
                         cyc, out_valid, out_res, out_status, issue_ready, fflags, e_valid, e_res, e_status, e_ready, mflags);
            end
            if (k >= 3 && k <= 5) begin
                n_checks++;
                if (out_valid !== (k == 4) || (k == 4 && out_res !== saved)) begin
                    n_fail++;
                    $display("FAIL race_visible k=%0d got v=%b res=%h want v=%b res=%h",
                             k, out_valid, out_res, (k == 4), saved);
                end
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            issue_valid = 1'($urandom);
            out_ready   = ($urandom_range(0, 3) != 0);
            fflags_clr  = ($urandom_range(0, 15) == 0);
            rst         = ($urandom_range(0, 99) == 0);
            rand_data();
            @(negedge clk);
            model_expect();
            n_checks++;
            if (out_valid !== e_valid || out_res !== e_res || out_status !== e_status ||
                issue_ready !== e_ready || fflags !== mflags) begin
                n_fail++;
                $display("FAIL random cyc=%0d got v=%b res=%h st=%b rdy=%b ff=%b want v=%b res=%h st=%b rdy=%b ff=%b",
                         cyc, out_valid, out_res, out_status, issue_ready, fflags, e_valid, e_res, e_status, e_ready, mflags);
            end
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; issue_valid = 1'b0; out_ready = 1'b0; fflags_clr = 1'b0;
        mul_res = '0; mul_status = '0;
        test_reset();
        test_single_op();
        settle();
        test_backpressure();
        settle();
        test_streaming();
        settle();
        test_fflags();
        settle();
        test_reset_midflight();
        settle();
        test_empty_race();
        settle();
        test_random();
        settle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
